// File: rtl/noc_interface_mc.sv
// ---------------------------------------------------------------------------
// noc_interface_mc
// Multi-channel protocol interface between a network-interface controller
// (NIc) and one IP-core. The NIc side issues opcode-based read/write commands
// that access per-channel input RAMs, output RAMs, config registers, the IP
// identifier and a sticky status/interrupt block. Each RAM channel keeps an
// auto-incrementing, wrapping pointer. Malformed commands set a sticky error.
//
// Ports
//   clk, rst_a          clock (rising edge) and synchronous active-high reset
//   en_s                slave enable; read/write/start ignored when low
//   conf_dbus           [5:2] opcode, [1:0] channel index
//   read, write         one-cycle command strobes
//   start               IP-core start request
//   data_in             write data / pointer value
//   data_out            registered read data (held until the next read)
//   data_out_valid      one-cycle pulse when data_out is updated
//   int_req             registered interrupt request
//   data_MemIn          IP-side read data of every input RAM
//   rd_addr_MemIn       IP-side read address of every input RAM
//   data_ConfigReg      config register at rd_addr_ConfigReg
//   rd_addr_ConfigReg   config register read address
//   data_MemOut         IP-side write data of every output RAM
//   wr_en_MemOut        IP-side write enables
//   wr_addr_MemOut      IP-side write addresses
//   start_IPcore        registered start pulse
//   status_IPcore       IP event bits, sampled every cycle
// ---------------------------------------------------------------------------
module noc_interface_mc #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned N_MEMI          = 2,
  parameter int unsigned N_MEMO          = 2,
  parameter int unsigned ADDR_WIDTH_MEMI = 6,
  parameter int unsigned ADDR_WIDTH_MEMO = 6,
  parameter int unsigned ADDR_WIDTH_CR   = 2,
  parameter int unsigned STAT_WIDTH      = 8,
  parameter logic [31:0] IP_ID           = 32'h00002001
) (
  input  logic                                clk,
  input  logic                                rst_a,
  input  logic                                en_s,
  input  logic [5:0]                          conf_dbus,
  input  logic                                read,
  input  logic                                write,
  input  logic                                start,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_out_valid,
  output logic                                int_req,
  output logic [N_MEMI*DATA_WIDTH-1:0]        data_MemIn,
  input  logic [N_MEMI*ADDR_WIDTH_MEMI-1:0]   rd_addr_MemIn,
  output logic [DATA_WIDTH-1:0]               data_ConfigReg,
  input  logic [ADDR_WIDTH_CR-1:0]            rd_addr_ConfigReg,
  input  logic [N_MEMO*DATA_WIDTH-1:0]        data_MemOut,
  input  logic [N_MEMO-1:0]                   wr_en_MemOut,
  input  logic [N_MEMO*ADDR_WIDTH_MEMO-1:0]   wr_addr_MemOut,
  output logic                                start_IPcore,
  input  logic [STAT_WIDTH-1:0]               status_IPcore
);

  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned AMI      = ADDR_WIDTH_MEMI;
  localparam int unsigned AMO      = ADDR_WIDTH_MEMO;
  localparam int unsigned ACR      = ADDR_WIDTH_CR;
  localparam int unsigned SW       = STAT_WIDTH;
  localparam int unsigned MI_DEPTH = 2 ** AMI;
  localparam int unsigned MO_DEPTH = 2 ** AMO;
  localparam int unsigned CR_NUM   = 2 ** ACR;

  localparam logic [3:0] OP_RD_ID      = 4'd0;
  localparam logic [3:0] OP_RD_STATUS  = 4'd1;
  localparam logic [3:0] OP_WR_CLRMASK = 4'd2;
  localparam logic [3:0] OP_SET_PTR_MI = 4'd3;
  localparam logic [3:0] OP_WR_MI      = 4'd4;
  localparam logic [3:0] OP_SET_PTR_MO = 4'd5;
  localparam logic [3:0] OP_RD_MO      = 4'd6;
  localparam logic [3:0] OP_SET_PTR_CR = 4'd8;
  localparam logic [3:0] OP_WR_CR      = 4'd9;
  localparam logic [3:0] OP_RD_PTR     = 4'd10;

  // Command decode
  logic [3:0] op_s;
  logic [1:0] ch_s;
  logic       cmd_s, both_s, op_known_s, op_rd_s, ch_ok_s, err_cmd_s, exec_s;

  // State
  logic [DW-1:0]  data_out_q, data_out_d;
  logic           data_out_valid_q, data_out_valid_d;
  logic           int_req_q, int_req_d;
  logic           start_ipcore_q, start_ipcore_d;
  logic [SW-1:0]  flags_q, flags_d;
  logic [SW-1:0]  mask_q, mask_d;
  logic           err_q, err_d;
  logic [AMI-1:0] ptr_mi_q [N_MEMI];
  logic [AMI-1:0] ptr_mi_d [N_MEMI];
  logic [AMO-1:0] ptr_mo_q [N_MEMO];
  logic [AMO-1:0] ptr_mo_d [N_MEMO];
  logic [ACR-1:0] ptr_cr_q, ptr_cr_d;
  logic [DW-1:0]  cr_q [CR_NUM];
  logic [DW-1:0]  cr_d [CR_NUM];

  // Helpers
  logic [SW-1:0]     clr_s;
  logic [N_MEMI-1:0] mi_we_s;
  logic [AMI-1:0]    ptr_mi_sel_s;
  logic [DW-1:0]     mo_word_s;
  logic [DW-1:0]     status_word_s;

  // RAM arrays (contents are not reset)
  logic [DW-1:0] mem_mi [N_MEMI][MI_DEPTH];
  logic [DW-1:0] mem_mo [N_MEMO][MO_DEPTH];
  logic [DW-1:0] memin_rd_q [N_MEMI];

  assign op_s = conf_dbus[5:2];
  assign ch_s = conf_dbus[1:0];

  // Classify the opcode: known or not, read or write direction, channel legal
  always_comb begin
    op_known_s = 1'b0;
    op_rd_s    = 1'b0;
    ch_ok_s    = 1'b1;
    case (op_s)
      OP_RD_ID, OP_RD_STATUS: begin
        op_known_s = 1'b1;
        op_rd_s    = 1'b1;
      end
      OP_WR_CLRMASK, OP_SET_PTR_CR, OP_WR_CR: begin
        op_known_s = 1'b1;
      end
      OP_SET_PTR_MI, OP_WR_MI: begin
        op_known_s = 1'b1;
        ch_ok_s    = (32'(ch_s) < N_MEMI);
      end
      OP_RD_PTR: begin
        op_known_s = 1'b1;
        op_rd_s    = 1'b1;
        ch_ok_s    = (32'(ch_s) < N_MEMI);
      end
      OP_SET_PTR_MO: begin
        op_known_s = 1'b1;
        ch_ok_s    = (32'(ch_s) < N_MEMO);
      end
      OP_RD_MO: begin
        op_known_s = 1'b1;
        op_rd_s    = 1'b1;
        ch_ok_s    = (32'(ch_s) < N_MEMO);
      end
      default: begin
        op_known_s = 1'b0;
      end
    endcase
  end

  // A malformed command only raises the sticky error and does nothing else
  assign cmd_s     = en_s & (read ^ write);
  assign both_s    = en_s & read & write;
  assign err_cmd_s = both_s | (cmd_s & (~op_known_s | ~ch_ok_s | (read != op_rd_s)));
  assign exec_s    = cmd_s & ~err_cmd_s;

  // Select the addressed channel's input pointer and output RAM word
  always_comb begin
    ptr_mi_sel_s = '0;
    mo_word_s    = '0;
    for (int i = 0; i < int'(N_MEMI); i++) begin
      ptr_mi_sel_s = (ch_s == 2'(i)) ? ptr_mi_q[i] : ptr_mi_sel_s;
    end
    for (int i = 0; i < int'(N_MEMO); i++) begin
      mo_word_s = (ch_s == 2'(i)) ? mem_mo[i][ptr_mo_q[i]] : mo_word_s;
    end
  end

  // Pack err/mask/flags into the status read word
  always_comb begin
    status_word_s             = '0;
    status_word_s[31]         = err_q;
    status_word_s[16 +: SW]   = mask_q;
    status_word_s[0 +: SW]    = flags_q;
  end

  // Next-state logic for command execution, flags, interrupt and start
  always_comb begin
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    mask_d           = mask_q;
    ptr_cr_d         = ptr_cr_q;
    clr_s            = '0;
    mi_we_s          = '0;
    for (int i = 0; i < int'(N_MEMI); i++) ptr_mi_d[i] = ptr_mi_q[i];
    for (int i = 0; i < int'(N_MEMO); i++) ptr_mo_d[i] = ptr_mo_q[i];
    for (int i = 0; i < int'(CR_NUM); i++) cr_d[i] = cr_q[i];

    if (exec_s) begin
      case (op_s)
        OP_RD_ID: begin
          data_out_d       = DW'(IP_ID);
          data_out_valid_d = 1'b1;
        end
        OP_RD_STATUS: begin
          data_out_d       = status_word_s;
          data_out_valid_d = 1'b1;
        end
        OP_WR_CLRMASK: begin
          clr_s  = data_in[SW-1:0];
          mask_d = data_in[16 +: SW];
        end
        OP_SET_PTR_MI: begin
          for (int i = 0; i < int'(N_MEMI); i++)
            ptr_mi_d[i] = (ch_s == 2'(i)) ? data_in[AMI-1:0] : ptr_mi_q[i];
        end
        OP_WR_MI: begin
          for (int i = 0; i < int'(N_MEMI); i++) begin
            mi_we_s[i]  = (ch_s == 2'(i));
            ptr_mi_d[i] = (ch_s == 2'(i)) ? ptr_mi_q[i] + AMI'(1'b1) : ptr_mi_q[i];
          end
        end
        OP_SET_PTR_MO: begin
          for (int i = 0; i < int'(N_MEMO); i++)
            ptr_mo_d[i] = (ch_s == 2'(i)) ? data_in[AMO-1:0] : ptr_mo_q[i];
        end
        OP_RD_MO: begin
          data_out_d       = mo_word_s;
          data_out_valid_d = 1'b1;
          for (int i = 0; i < int'(N_MEMO); i++)
            ptr_mo_d[i] = (ch_s == 2'(i)) ? ptr_mo_q[i] + AMO'(1'b1) : ptr_mo_q[i];
        end
        OP_SET_PTR_CR: begin
          ptr_cr_d = data_in[ACR-1:0];
        end
        OP_WR_CR: begin
          cr_d[ptr_cr_q] = data_in;
          ptr_cr_d       = ptr_cr_q + ACR'(1'b1);
        end
        OP_RD_PTR: begin
          data_out_d          = '0;
          data_out_d[AMI-1:0] = ptr_mi_sel_s;
          data_out_valid_d    = 1'b1;
        end
        default: begin
          data_out_valid_d = 1'b0;
        end
      endcase
    end else begin
      data_out_valid_d = 1'b0;
    end

    // New events win over a clear in the same cycle
    flags_d = (flags_q & ~clr_s) | status_IPcore;
    int_req_d = |(flags_d & mask_d);

    if (err_cmd_s) begin
      err_d = 1'b1;
    end else if (exec_s && (op_s == OP_WR_CLRMASK) && data_in[31]) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    start_ipcore_d = start & en_s;
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_a) begin
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      int_req_q        <= 1'b0;
      start_ipcore_q   <= 1'b0;
      flags_q          <= '0;
      mask_q           <= '0;
      err_q            <= 1'b0;
      ptr_cr_q         <= '0;
      for (int i = 0; i < int'(N_MEMI); i++) ptr_mi_q[i] <= '0;
      for (int i = 0; i < int'(N_MEMO); i++) ptr_mo_q[i] <= '0;
      for (int i = 0; i < int'(CR_NUM); i++) cr_q[i] <= '0;
    end else begin
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      int_req_q        <= int_req_d;
      start_ipcore_q   <= start_ipcore_d;
      flags_q          <= flags_d;
      mask_q           <= mask_d;
      err_q            <= err_d;
      ptr_cr_q         <= ptr_cr_d;
      for (int i = 0; i < int'(N_MEMI); i++) ptr_mi_q[i] <= ptr_mi_d[i];
      for (int i = 0; i < int'(N_MEMO); i++) ptr_mo_q[i] <= ptr_mo_d[i];
      for (int i = 0; i < int'(CR_NUM); i++) cr_q[i] <= cr_d[i];
    end
  end

  // Input RAMs: NIc writes through the pointer, IP reads synchronously
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_MEMI); i++) begin
      if (mi_we_s[i]) mem_mi[i][ptr_mi_q[i]] <= data_in;
      memin_rd_q[i] <= mem_mi[i][rd_addr_MemIn[i*AMI +: AMI]];
    end
  end

  // Output RAMs: IP writes; NIc reads through the registered data_out path
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_MEMO); i++) begin
      if (wr_en_MemOut[i])
        mem_mo[i][wr_addr_MemOut[i*AMO +: AMO]] <= data_MemOut[i*DW +: DW];
    end
  end

  for (genvar g = 0; g < int'(N_MEMI); g++) begin : g_memin_out
    assign data_MemIn[g*DW +: DW] = memin_rd_q[g];
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign int_req        = int_req_q;
  assign start_IPcore   = start_ipcore_q;
  assign data_ConfigReg = cr_q[rd_addr_ConfigReg];

endmodule

// File: tb/tb_noc_interface_mc.sv
// Directed bench for noc_interface_mc with default parameters.
module tb_noc_interface_mc;

  logic        clk = 1'b0;
  logic        rst_a, en_s, read, write, start;
  logic [5:0]  conf_dbus;
  logic [31:0] data_in, data_out, data_ConfigReg;
  logic        data_out_valid, int_req, start_IPcore;
  logic [63:0] data_MemIn, data_MemOut;
  logic [11:0] rd_addr_MemIn, wr_addr_MemOut;
  logic [1:0]  rd_addr_ConfigReg, wr_en_MemOut;
  logic [7:0]  status_IPcore;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  noc_interface_mc dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .conf_dbus(conf_dbus),
    .read(read), .write(write), .start(start), .data_in(data_in),
    .data_out(data_out), .data_out_valid(data_out_valid), .int_req(int_req),
    .data_MemIn(data_MemIn), .rd_addr_MemIn(rd_addr_MemIn),
    .data_ConfigReg(data_ConfigReg), .rd_addr_ConfigReg(rd_addr_ConfigReg),
    .data_MemOut(data_MemOut), .wr_en_MemOut(wr_en_MemOut),
    .wr_addr_MemOut(wr_addr_MemOut), .start_IPcore(start_IPcore),
    .status_IPcore(status_IPcore)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle command; outputs are sampled 1 time unit after the edge
  task automatic cmd(input logic [3:0] op, input logic [1:0] ch,
                     input logic r, input logic w, input logic [31:0] d);
    en_s = 1'b1; conf_dbus = {op, ch}; read = r; write = w; data_in = d;
    tick();
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; en_s = 1'b0; read = 1'b0; write = 1'b0; start = 1'b0;
    conf_dbus = 6'd0; data_in = 32'd0; rd_addr_MemIn = 12'd0;
    rd_addr_ConfigReg = 2'd0; data_MemOut = 64'd0; wr_en_MemOut = 2'b00;
    wr_addr_MemOut = 12'd0; status_IPcore = 8'd0;
    repeat (2) tick();
    chk("rst_dout", data_out, 32'd0);
    chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
    chk("rst_irq", {31'd0, int_req}, 32'd0);
    chk("rst_start", {31'd0, start_IPcore}, 32'd0);
    chk("rst_cr", data_ConfigReg, 32'd0);
    rst_a = 1'b0;

    // ID and status after reset
    cmd(4'd0, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("id", data_out, 32'h00002001);
    chk("id_valid", {31'd0, data_out_valid}, 32'd1);
    tick();
    chk("id_valid_drop", {31'd0, data_out_valid}, 32'd0);
    chk("id_hold", data_out, 32'h00002001);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("status0", data_out, 32'd0);

    // Input RAM pointer wrap on channel 1
    cmd(4'd3, 2'd1, 1'b0, 1'b1, 32'd62);
    cmd(4'd4, 2'd1, 1'b0, 1'b1, 32'hAAAA0001);
    cmd(4'd4, 2'd1, 1'b0, 1'b1, 32'hBBBB0002);
    cmd(4'd4, 2'd1, 1'b0, 1'b1, 32'hCCCC0003);
    cmd(4'd4, 2'd1, 1'b0, 1'b1, 32'hDDDD0004);
    cmd(4'd10, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF);
    chk("rd_ptr_wrap", data_out, 32'd2);
    rd_addr_MemIn = {6'd62, 6'd0}; tick();
    chk("mi1_62", data_MemIn[63:32], 32'hAAAA0001);
    rd_addr_MemIn = {6'd63, 6'd0}; tick();
    chk("mi1_63", data_MemIn[63:32], 32'hBBBB0002);
    rd_addr_MemIn = {6'd0, 6'd0}; tick();
    chk("mi1_0", data_MemIn[63:32], 32'hCCCC0003);
    rd_addr_MemIn = {6'd1, 6'd0}; tick();
    chk("mi1_1", data_MemIn[63:32], 32'hDDDD0004);

    // IP fills output RAM 0; NIc reads back-to-back
    wr_en_MemOut = 2'b01;
    wr_addr_MemOut = {6'd0, 6'd5}; data_MemOut = {32'd0, 32'h00000055}; tick();
    wr_addr_MemOut = {6'd0, 6'd6}; data_MemOut = {32'd0, 32'h00000066}; tick();
    wr_addr_MemOut = {6'd0, 6'd0}; data_MemOut = {32'd0, 32'h000000AB}; tick();
    wr_en_MemOut = 2'b00;
    cmd(4'd5, 2'd0, 1'b0, 1'b1, 32'd5);
    en_s = 1'b1; conf_dbus = {4'd6, 2'd0}; read = 1'b1;
    tick();
    chk("mo_first", data_out, 32'h00000055);
    chk("mo_first_v", {31'd0, data_out_valid}, 32'd1);
    tick();
    chk("mo_second", data_out, 32'h00000066);
    chk("mo_second_v", {31'd0, data_out_valid}, 32'd1);
    read = 1'b0;
    tick();
    chk("mo_v_drop", {31'd0, data_out_valid}, 32'd0);

    // Flags, mask and interrupt
    status_IPcore = 8'h04; tick(); status_IPcore = 8'h00;
    chk("irq_masked", {31'd0, int_req}, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("flags_set", data_out, 32'h00000004);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h00040000);
    chk("irq_unmask", {31'd0, int_req}, 32'd1);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h00040004);
    chk("irq_clear", {31'd0, int_req}, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("status_mask", data_out, 32'h00040000);
    status_IPcore = 8'h04;
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h00040004);
    status_IPcore = 8'h00;
    chk("set_wins", {31'd0, int_req}, 32'd1);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h00040004);
    chk("irq_clear2", {31'd0, int_req}, 32'd0);

    // Start pulse follows start & en_s with one cycle latency
    start = 1'b1; tick();
    chk("start_1", {31'd0, start_IPcore}, 32'd1);
    tick();
    chk("start_held", {31'd0, start_IPcore}, 32'd1);
    en_s = 1'b0; tick();
    chk("start_gated", {31'd0, start_IPcore}, 32'd0);
    start = 1'b0; en_s = 1'b1;

    // Protocol errors
    en_s = 1'b1; conf_dbus = {4'd0, 2'd0}; read = 1'b1; write = 1'b1; tick();
    read = 1'b0; write = 1'b0;
    chk("both_no_valid", {31'd0, data_out_valid}, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("err_both", data_out, 32'h80040000);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h80040000);
    cmd(4'd4, 2'd3, 1'b0, 1'b1, 32'h12345678);
    cmd(4'd10, 2'd1, 1'b1, 1'b0, 32'd0);
    chk("err_ptr_kept", data_out, 32'd2);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("err_badch", data_out, 32'h80040000);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h80040000);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("err_cleared", data_out, 32'h00040000);
    cmd(4'd9, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("wrongdir_no_valid", {31'd0, data_out_valid}, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("err_wrongdir", data_out, 32'h80040000);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h80040000);
    en_s = 1'b0; conf_dbus = {4'd7, 2'd0}; write = 1'b1; tick();
    write = 1'b0;
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("en_off_no_err", data_out, 32'h00040000);
    cmd(4'd7, 2'd0, 1'b0, 1'b1, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("err_undef_op", data_out, 32'h80040000);
    cmd(4'd2, 2'd0, 1'b0, 1'b1, 32'h80040000);

    // Config registers with pointer wrap
    cmd(4'd8, 2'd0, 1'b0, 1'b1, 32'd3);
    cmd(4'd9, 2'd0, 1'b0, 1'b1, 32'hC0DE0003);
    cmd(4'd9, 2'd0, 1'b0, 1'b1, 32'hC0DE0000);
    rd_addr_ConfigReg = 2'd3; #1;
    chk("cr3", data_ConfigReg, 32'hC0DE0003);
    rd_addr_ConfigReg = 2'd0; #1;
    chk("cr0_wrap", data_ConfigReg, 32'hC0DE0000);
    rd_addr_ConfigReg = 2'd1; #1;
    chk("cr1", data_ConfigReg, 32'd0);

    // Reset in the middle of an output RAM burst
    status_IPcore = 8'h04; tick(); status_IPcore = 8'h00;
    chk("irq_pre_rst", {31'd0, int_req}, 32'd1);
    cmd(4'd5, 2'd0, 1'b0, 1'b1, 32'd5);
    en_s = 1'b1; conf_dbus = {4'd6, 2'd0}; read = 1'b1;
    tick();
    chk("burst_first", data_out, 32'h00000055);
    rst_a = 1'b1; tick();
    rst_a = 1'b0; read = 1'b0;
    chk("rst_mid_dout", data_out, 32'd0);
    chk("rst_mid_valid", {31'd0, data_out_valid}, 32'd0);
    chk("rst_mid_irq", {31'd0, int_req}, 32'd0);
    rd_addr_ConfigReg = 2'd3; #1;
    chk("rst_mid_cr", data_ConfigReg, 32'd0);
    cmd(4'd10, 2'd1, 1'b1, 1'b0, 32'd0);
    chk("rst_mid_ptr_mi", data_out, 32'd0);
    cmd(4'd1, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("rst_mid_status", data_out, 32'd0);
    cmd(4'd6, 2'd0, 1'b1, 1'b0, 32'd0);
    chk("rst_mid_ptr_mo", data_out, 32'h000000AB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
